// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit RISC controller: FSM states, opcode/op
// field encodings and one-hot register-field selects for the decoder.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_WR_IMM = 3'd2,
        S_GET_A  = 3'd3,
        S_GET_B  = 3'd4,
        S_ALU    = 3'd5,
        S_WR_RD  = 3'd6,
        S_CMP    = 3'd7
    } state_t;

    localparam logic [2:0] OPC_MOV   = 3'b110;
    localparam logic [2:0] OPC_ALU   = 3'b101;

    localparam logic [1:0] OP_MOVIMM = 2'b10;
    localparam logic [1:0] OP_MOVREG = 2'b00;
    localparam logic [1:0] OP_ADD    = 2'b00;
    localparam logic [1:0] OP_CMP    = 2'b01;
    localparam logic [1:0] OP_AND    = 2'b10;
    localparam logic [1:0] OP_MVN    = 2'b11;

    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b001;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b100;

endpackage

// File: rtl/cpu_controller.sv
// Instruction register plus Moore control FSM that sequences one instruction
// per start pulse and drives the decoder/datapath strobes.
module cpu_controller
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] in,
    input  logic        s,
    output logic [15:0] ir,
    output logic [2:0]  nsel,
    output logic        vsel,
    output logic        loada,
    output logic        loadb,
    output logic        asel,
    output logic        bsel,
    output logic        loadc,
    output logic        loads,
    output logic        write,
    output logic        w,
    output logic        illegal
);

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;

    logic [2:0] opcode;
    logic [1:0] op;
    logic       is_mov_imm, is_mov_reg, is_cmp, is_alu;

    assign opcode     = ir_q[15:13];
    assign op         = ir_q[12:11];
    assign is_mov_imm = (opcode == OPC_MOV) && (op == OP_MOVIMM);
    assign is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOVREG);
    assign is_alu     = (opcode == OPC_ALU);
    assign is_cmp     = is_alu && (op == OP_CMP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_WAIT;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // ir only changes while idle, so it is stable for the whole instruction.
    assign ir_d = ((state_q == S_WAIT) && load) ? in : ir_q;
    assign ir   = ir_q;

    always_comb begin
        state_d = state_q;
        nsel    = NSEL_NONE;
        vsel    = 1'b0;
        loada   = 1'b0;
        loadb   = 1'b0;
        asel    = 1'b0;
        bsel    = 1'b0;
        loadc   = 1'b0;
        loads   = 1'b0;
        write   = 1'b0;
        w       = 1'b0;
        illegal = 1'b0;

        case (state_q)
            S_WAIT: begin
                w = 1'b1;
                if (!load && s)
                    state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_mov_imm)
                    state_d = S_WR_IMM;
                else if (is_alu && (op != OP_MVN))
                    state_d = S_GET_A;
                else if (is_mov_reg || (is_alu && (op == OP_MVN)))
                    state_d = S_GET_B;
                else begin
                    state_d = S_WAIT;
                    illegal = 1'b1;
                end
            end
            S_WR_IMM: begin
                nsel    = NSEL_RN;
                vsel    = 1'b1;
                write   = 1'b1;
                state_d = S_WAIT;
            end
            S_GET_A: begin
                nsel    = NSEL_RN;
                loada   = 1'b1;
                state_d = S_GET_B;
            end
            S_GET_B: begin
                nsel    = NSEL_RM;
                loadb   = 1'b1;
                state_d = is_cmp ? S_CMP : S_ALU;
            end
            S_ALU: begin
                // MOV reg passes 0 + shifted Rm through the ALU.
                loadc   = 1'b1;
                asel    = is_mov_reg;
                state_d = S_WR_RD;
            end
            S_WR_RD: begin
                nsel    = NSEL_RD;
                write   = 1'b1;
                state_d = S_WAIT;
            end
            S_CMP: begin
                loads   = 1'b1;
                state_d = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

endmodule
